// File: rtl/pc_context_switch.sv
// Fetch-PC owner that saves/restores kernel and program return PCs on every mode edge
// and relocates program-mode fetches by a base register. Optional macro: PC_BOUNDS_CHECK_EN.
module pc_context_switch #(
    parameter int unsigned     W            = 10,
    parameter logic [W-1:0]    KERNEL_ENTRY = {W{1'b0}},
    parameter logic [W-1:0]    PROG_ENTRY   = {W{1'b0}}
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         prog_or_kernel,
    input  logic         pc_write,
    input  logic [W-1:0] pc_next,
    input  logic         ctx_load,
    input  logic [W-1:0] ctx_pc,
    input  logic [W-1:0] ctx_base,
    input  logic [W-1:0] ctx_limit,
    output logic [W-1:0] pc,
    output logic [W-1:0] inst_addr,
    output logic         switching,
    output logic         mode_q,
    output logic         bounds_fault
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } state_t;

    localparam logic [W-1:0] PC_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] PC_ZERO = {W{1'b0}};

    state_t       state_r, state_nxt_s;
    logic [W-1:0] pc_r, pc_nxt_s;
    logic [W-1:0] kern_save_r, kern_save_nxt_s;
    logic [W-1:0] prog_save_r, prog_save_nxt_s;
    logic [W-1:0] base_r, base_nxt_s;
    logic         mode_r, mode_nxt_s;
    logic         target_r, target_nxt_s;
    logic         switching_r, switching_nxt_s;
    logic         edge_s;
    logic         ctx_take_s;

    assign edge_s     = (state_r == ST_RUN) && (prog_or_kernel != mode_r);
    // Context registers are only writable by the kernel while no switch is in flight.
    assign ctx_take_s = (state_r == ST_RUN) && !edge_s && ctx_load && !mode_r;

    // Next-state and next-register computation for the RUN/SWITCH controller.
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        kern_save_nxt_s = kern_save_r;
        prog_save_nxt_s = prog_save_r;
        base_nxt_s      = base_r;
        mode_nxt_s      = mode_r;
        target_nxt_s    = target_r;
        switching_nxt_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (edge_s) begin
                    // Return point is the instruction after the one that trapped.
                    if (mode_r) begin
                        prog_save_nxt_s = pc_r + PC_ONE;
                    end else begin
                        kern_save_nxt_s = pc_r + PC_ONE;
                    end
                    target_nxt_s    = prog_or_kernel;
                    switching_nxt_s = 1'b1;
                    state_nxt_s     = ST_SWITCH;
                end else begin
                    if (pc_write) begin
                        pc_nxt_s = pc_next;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                    if (ctx_take_s) begin
                        prog_save_nxt_s = ctx_pc;
                        base_nxt_s      = ctx_base;
                    end else begin
                        prog_save_nxt_s = prog_save_r;
                        base_nxt_s      = base_r;
                    end
                end
            end
            ST_SWITCH: begin
                if (target_r) begin
                    pc_nxt_s = prog_save_r;
                end else begin
                    pc_nxt_s = kern_save_r;
                end
                mode_nxt_s  = target_r;
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State and context register bank.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_RUN;
            pc_r        <= KERNEL_ENTRY;
            kern_save_r <= KERNEL_ENTRY;
            prog_save_r <= PROG_ENTRY;
            base_r      <= PC_ZERO;
            mode_r      <= 1'b0;
            target_r    <= 1'b0;
            switching_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            kern_save_r <= kern_save_nxt_s;
            prog_save_r <= prog_save_nxt_s;
            base_r      <= base_nxt_s;
            mode_r      <= mode_nxt_s;
            target_r    <= target_nxt_s;
            switching_r <= switching_nxt_s;
        end
    end

`ifdef PC_BOUNDS_CHECK_EN
    logic [W-1:0] limit_r, limit_nxt_s;
    logic         fault_r, fault_nxt_s;

    // Limit capture and sticky fault; a completed program-to-kernel switch clears it.
    always_comb begin
        if (ctx_take_s) begin
            limit_nxt_s = ctx_limit;
        end else begin
            limit_nxt_s = limit_r;
        end
        if ((state_r == ST_SWITCH) && !target_r) begin
            fault_nxt_s = 1'b0;
        end else if ((state_r == ST_RUN) && mode_r && (pc_r >= limit_r)) begin
            fault_nxt_s = 1'b1;
        end else begin
            fault_nxt_s = fault_r;
        end
    end

    // Bounds-check registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            limit_r <= PC_ZERO;
            fault_r <= 1'b0;
        end else begin
            limit_r <= limit_nxt_s;
            fault_r <= fault_nxt_s;
        end
    end

    assign bounds_fault = fault_r;
`else
    logic limit_unused_s;
    assign limit_unused_s = ^ctx_limit;
    assign bounds_fault   = 1'b0;
`endif

    assign pc        = pc_r;
    assign mode_q    = mode_r;
    assign switching = switching_r;
    assign inst_addr = mode_r ? (pc_r + base_r) : pc_r;

endmodule

// File: tb/tb_pc_context_switch.sv
// Directed self-checking bench for pc_context_switch (W = 10, entries 0).
module tb_pc_context_switch;

    localparam int W = 10;

`ifdef PC_BOUNDS_CHECK_EN
    localparam logic FEAT = 1'b1;
`else
    localparam logic FEAT = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         prog_or_kernel;
    logic         pc_write;
    logic [W-1:0] pc_next;
    logic         ctx_load;
    logic [W-1:0] ctx_pc;
    logic [W-1:0] ctx_base;
    logic [W-1:0] ctx_limit;
    logic [W-1:0] pc;
    logic [W-1:0] inst_addr;
    logic         switching;
    logic         mode_q;
    logic         bounds_fault;

    int vectors    = 0;
    int miscompares = 0;

    pc_context_switch #(.W(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .prog_or_kernel (prog_or_kernel),
        .pc_write       (pc_write),
        .pc_next        (pc_next),
        .ctx_load       (ctx_load),
        .ctx_pc         (ctx_pc),
        .ctx_base       (ctx_base),
        .ctx_limit      (ctx_limit),
        .pc             (pc),
        .inst_addr      (inst_addr),
        .switching      (switching),
        .mode_q         (mode_q),
        .bounds_fault   (bounds_fault)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; prog_or_kernel = 1'b0; pc_write = 1'b1; pc_next = 10'd5;
        ctx_load = 1'b0; ctx_pc = 10'd0; ctx_base = 10'd0; ctx_limit = 10'd0;
        // Reset holds despite pc_write
        step(); step(); step();
        check_val("rst_pc", 32'(pc), 32'd0);
        check_val("rst_addr", 32'(inst_addr), 32'd0);
        check_val("rst_sw", 32'(switching), 32'd0);
        check_val("rst_mode", 32'(mode_q), 32'd0);
        check_val("rst_fault", 32'(bounds_fault), 32'd0);
        reset = 1'b0;
        step();
        check_val("first_write", 32'(pc), 32'd5);

        // Kernel at 20, load program context
        pc_next = 10'd20; step();
        pc_write = 1'b0;
        ctx_load = 1'b1; ctx_pc = 10'd3; ctx_base = 10'd100; ctx_limit = 10'd4;
        step();
        ctx_load = 1'b0;
        check_val("ctx_load_pc", 32'(pc), 32'd20);

        // Kernel -> program, pc_write=50 must be ignored in edge and SWITCH
        prog_or_kernel = 1'b1; pc_write = 1'b1; pc_next = 10'd50;
        step();
        check_val("edge_sw", 32'(switching), 32'd1);
        check_val("edge_pc", 32'(pc), 32'd20);
        check_val("edge_mode", 32'(mode_q), 32'd0);
        step();
        pc_write = 1'b0;
        check_val("k2p_pc", 32'(pc), 32'd3);
        check_val("k2p_mode", 32'(mode_q), 32'd1);
        check_val("k2p_addr", 32'(inst_addr), 32'd103);
        check_val("k2p_sw", 32'(switching), 32'd0);

        // Program pc reaches limit 4, then 7
        pc_write = 1'b1; pc_next = 10'd4; step();
        check_val("fault_pre", 32'(bounds_fault), 32'd0);
        pc_next = 10'd7; step();
        pc_write = 1'b0;
        check_val("prog_pc7", 32'(pc), 32'd7);
        check_val("prog_addr", 32'(inst_addr), 32'd107);
        check_val("fault_set", 32'(bounds_fault), 32'(FEAT));

        // Program -> kernel
        prog_or_kernel = 1'b0;
        step();
        check_val("fault_sticky", 32'(bounds_fault), 32'(FEAT));
        step();
        check_val("p2k_pc", 32'(pc), 32'd21);
        check_val("p2k_addr", 32'(inst_addr), 32'd21);
        check_val("fault_clr", 32'(bounds_fault), 32'd0);

        // Kernel -> program resumes at 8
        prog_or_kernel = 1'b1;
        step(); step();
        check_val("resume_pc", 32'(pc), 32'd8);
        check_val("resume_addr", 32'(inst_addr), 32'd108);

        // Back-to-back toggles: 1->0 then 0->1 during SWITCH, then back to 0
        prog_or_kernel = 1'b0; step();
        prog_or_kernel = 1'b1; step();
        check_val("b2b_k_pc", 32'(pc), 32'd22);
        check_val("b2b_k_mode", 32'(mode_q), 32'd0);
        step();
        check_val("b2b_edge2", 32'(switching), 32'd1);
        prog_or_kernel = 1'b0; step();
        check_val("b2b_p_pc", 32'(pc), 32'd9);
        check_val("b2b_p_mode", 32'(mode_q), 32'd1);
        step(); step();
        check_val("b2b_final_mode", 32'(mode_q), 32'd0);
        check_val("b2b_final_pc", 32'(pc), 32'd23);
        check_val("b2b_fault", 32'(bounds_fault), 32'd0);

        // Wrap: kernel pc 1023 saves 0
        pc_write = 1'b1; pc_next = 10'd1023; step();
        pc_write = 1'b0;
        prog_or_kernel = 1'b1; step(); step();
        check_val("wrap_prog_pc", 32'(pc), 32'd10);
        prog_or_kernel = 1'b0; step(); step();
        check_val("wrap_ret", 32'(pc), 32'd0);

        // Relocation wraps; ctx_load in program mode ignored
        ctx_load = 1'b1; ctx_pc = 10'd30; ctx_base = 10'd1000; ctx_limit = 10'd1023;
        step();
        ctx_load = 1'b0;
        prog_or_kernel = 1'b1; step(); step();
        check_val("reloc_pc", 32'(pc), 32'd30);
        check_val("reloc_wrap", 32'(inst_addr), 32'd6);
        ctx_load = 1'b1; ctx_pc = 10'd1; ctx_base = 10'd5; ctx_limit = 10'd0;
        step();
        ctx_load = 1'b0;
        check_val("prog_ld_addr", 32'(inst_addr), 32'd6);
        step();
        check_val("prog_ld_limit", 32'(bounds_fault), 32'd0);

        // Reset during SWITCH loses contexts
        prog_or_kernel = 1'b0; step();
        check_val("mid_sw", 32'(switching), 32'd1);
        reset = 1'b1; step();
        check_val("midrst_pc", 32'(pc), 32'd0);
        check_val("midrst_mode", 32'(mode_q), 32'd0);
        check_val("midrst_sw", 32'(switching), 32'd0);
        reset = 1'b0; step();
        check_val("post_rst_sw", 32'(switching), 32'd0);
        prog_or_kernel = 1'b1; step(); step();
        check_val("post_rst_mode", 32'(mode_q), 32'd1);
        check_val("post_rst_pc", 32'(pc), 32'd0);
        check_val("post_rst_addr", 32'(inst_addr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
